// File: rtl/peripheral_msi_init_pkg.sv
// Shared definitions for the MSI/UART peripheral bring-up master: register map, FSM states and
// the step table. PERIPHERAL_MSI_INIT_VERIFY_EN adds a final LCR read-back step.
package peripheral_msi_init_pkg;

    localparam logic [2:0] RBR_THR_DLL = 3'd0;
    localparam logic [2:0] IER_DLM     = 3'd1;
    localparam logic [2:0] IIR_FCR     = 3'd2;
    localparam logic [2:0] LCR         = 3'd3;
    localparam logic [2:0] LSR         = 3'd5;

    localparam int unsigned LCR_DLAB = 7;

`ifdef PERIPHERAL_MSI_INIT_VERIFY_EN
    localparam logic [2:0] LAST_STEP = 3'd6;
`else
    localparam logic [2:0] LAST_STEP = 3'd5;
`endif

    typedef enum logic [2:0] {StIdle, StBus, StGap, StDone, StErr} state_e;

    typedef struct packed {
        logic       we;
        logic [2:0] adr;
        logic [7:0] dat;
    } step_t;

    function automatic step_t step_entry(input logic [2:0]  step,
                                         input logic [15:0] divisor,
                                         input logic [7:0]  lcr_fmt,
                                         input logic [7:0]  fcr_val,
                                         input logic [7:0]  ier_val);
        step_t e;
        e = '{we: 1'b1, adr: LCR, dat: 8'h00};
        case (step)
            3'd0: begin
                e.adr = LCR;
                e.dat = lcr_fmt;
                e.dat[LCR_DLAB] = 1'b1;
            end
            3'd1: begin e.adr = RBR_THR_DLL; e.dat = divisor[7:0];  end
            3'd2: begin e.adr = IER_DLM;     e.dat = divisor[15:8]; end
            3'd3: begin
                e.adr = LCR;
                e.dat = lcr_fmt;
                e.dat[LCR_DLAB] = 1'b0;
            end
            3'd4: begin e.adr = IIR_FCR;     e.dat = fcr_val;       end
            3'd5: begin e.adr = IER_DLM;     e.dat = ier_val;       end
            // Read-back of LCR, only reached when verification is built in.
            default: begin e.we = 1'b0; e.adr = LCR; e.dat = 8'h00; end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/peripheral_msi_wb_init.sv
// Wishbone master that programs the 16550-style register file after reset or on start_i.
// Optional build macro PERIPHERAL_MSI_INIT_VERIFY_EN appends an LCR read-back check.
module peripheral_msi_wb_init
    import peripheral_msi_init_pkg::*;
#(
    parameter logic [15:0]  DIVISOR = 16'd27,
    parameter logic [7:0]   LCR_FMT = 8'h03,
    parameter logic [7:0]   FCR_VAL = 8'hC7,
    parameter logic [7:0]   IER_VAL = 8'h01,
    parameter int unsigned  TIMEOUT = 16
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [2:0] wbm_adr_o,
    output logic [7:0] wbm_dat_o,
    input  logic [7:0] wbm_dat_i,
    output logic       wbm_we_o,
    output logic       wbm_stb_o,
    output logic       wbm_cyc_o,
    output logic [3:0] wbm_sel_o,
    input  logic       wbm_ack_i
);

    // A disabled timeout still needs a 1-bit counter to keep widths legal.
    localparam int unsigned ToW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e         state_q, state_d;
    logic [2:0]     step_q, step_d;
    logic [ToW-1:0] to_q, to_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    step_t          cur;
    logic           in_bus;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            step_q  <= 3'd0;
            to_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            to_q    <= to_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cur = step_entry(step_q, DIVISOR, LCR_FMT, FCR_VAL, IER_VAL);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        to_d    = to_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start_i) begin
                    state_d = StBus;
                    step_d  = 3'd0;
                    to_d    = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            StBus: begin
                // Ack takes priority over a timeout firing in the same cycle.
                if (wbm_ack_i) begin
                    state_d = StGap;
`ifdef PERIPHERAL_MSI_INIT_VERIFY_EN
                    if (!cur.we && (wbm_dat_i != (LCR_FMT & 8'h7F))) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
`endif
                end else if (TIMEOUT > 0) begin
                    if (to_q == ToW'(TIMEOUT - 1)) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end else begin
                        to_d = to_q + ToW'(1);
                    end
                end
            end
            StGap: begin
                if (step_q == LAST_STEP) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    state_d = StBus;
                    step_d  = step_q + 3'd1;
                    to_d    = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifndef PERIPHERAL_MSI_INIT_VERIFY_EN
    logic unused_dat;
    assign unused_dat = ^wbm_dat_i;
`endif

    assign in_bus    = (state_q == StBus);
    assign wbm_cyc_o = in_bus;
    assign wbm_stb_o = in_bus;
    assign wbm_sel_o = in_bus ? 4'b1111 : 4'b0000;
    assign wbm_we_o  = in_bus & cur.we;
    assign wbm_adr_o = in_bus ? cur.adr : 3'd0;
    assign wbm_dat_o = in_bus ? cur.dat : 8'h00;
    assign busy_o    = in_bus | (state_q == StGap);
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_peripheral_msi_wb_init.sv
// Bench for peripheral_msi_wb_init: transaction-level bus model, 2-cycle-ack responder and
// directed status checks. Define PERIPHERAL_MSI_INIT_VERIFY_EN to exercise the read-back step.
module tb_peripheral_msi_wb_init;

    localparam logic [15:0] DIV1    = 16'd27;
    localparam logic [15:0] DIV2    = 16'h0145;
    localparam logic [7:0]  LCR_FMT = 8'h03;
    localparam logic [7:0]  FCR_VAL = 8'hC7;
    localparam logic [7:0]  IER_VAL = 8'h01;
`ifdef PERIPHERAL_MSI_INIT_VERIFY_EN
    localparam int N_STEPS = 7;
`else
    localparam int N_STEPS = 6;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ack = 1'b0;
    logic [7:0] rd_data = 8'h03;

    logic busy1, done1, err1, we1, stb1, cyc1;
    logic busy2, done2, err2, we2, stb2, cyc2;
    logic [2:0] adr1, adr2;
    logic [7:0] dat1, dat2;
    logic [3:0] sel1, sel2;

    int checks = 0;
    int errors = 0;

    // Model / responder state
    int idx = 0;
    int scnt = 0;
    int no_ack_step = 99;
    bit hs_prev = 0;
    bit bus_allowed = 1;
    int n_log = 0;
    logic [2:0] log_adr1 [16];
    logic [7:0] log_dat1 [16];
    logic [7:0] log_dat2 [16];

    always #5 clk = ~clk;

    peripheral_msi_wb_init dut (
        .wb_clk_i (clk),   .wb_rst_i (rst),   .start_i (start),
        .busy_o   (busy1), .done_o   (done1), .err_o   (err1),
        .wbm_adr_o(adr1),  .wbm_dat_o(dat1),  .wbm_dat_i(rd_data),
        .wbm_we_o (we1),   .wbm_stb_o(stb1),  .wbm_cyc_o(cyc1),
        .wbm_sel_o(sel1),  .wbm_ack_i(ack)
    );

    peripheral_msi_wb_init #(.DIVISOR(DIV2)) dut_div (
        .wb_clk_i (clk),   .wb_rst_i (rst),   .start_i (start),
        .busy_o   (busy2), .done_o   (done2), .err_o   (err2),
        .wbm_adr_o(adr2),  .wbm_dat_o(dat2),  .wbm_dat_i(rd_data),
        .wbm_we_o (we2),   .wbm_stb_o(stb2),  .wbm_cyc_o(cyc2),
        .wbm_sel_o(sel2),  .wbm_ack_i(ack)
    );

    // Expected {we, adr, dat} for each step of the programming sequence.
    function automatic logic [11:0] exp_txn(input int s, input logic [15:0] div);
        case (s)
            0: return {1'b1, 3'd3, 8'h80 | LCR_FMT};
            1: return {1'b1, 3'd0, div[7:0]};
            2: return {1'b1, 3'd1, div[15:8]};
            3: return {1'b1, 3'd3, LCR_FMT & 8'h7F};
            4: return {1'b1, 3'd2, FCR_VAL};
            5: return {1'b1, 3'd1, IER_VAL};
            default: return {1'b0, 3'd3, 8'h00};
        endcase
    endfunction

    function automatic bit txn_ok(input logic we, input logic [2:0] adr, input logic [7:0] dat,
                                  input logic [11:0] e);
        if (we !== e[11] || adr !== e[10:8]) return 0;
        if (e[11] && dat !== e[7:0]) return 0;
        return 1;
    endfunction

    always @(negedge clk) begin
        logic [11:0] e1, e2;
        if (hs_prev) idx = idx + 1;
        e1 = exp_txn(idx % N_STEPS, DIV1);
        e2 = exp_txn(idx % N_STEPS, DIV2);
        checks++;
        if (sel1 !== (cyc1 ? 4'hF : 4'h0) || stb1 !== cyc1 ||
            sel2 !== (cyc2 ? 4'hF : 4'h0) || stb2 !== cyc2) begin
            errors++;
            $display("FAIL bus_ctl: cyc=%b/%b stb=%b/%b sel=%h/%h, required stb=cyc, sel=F when cyc",
                     cyc1, cyc2, stb1, stb2, sel1, sel2);
        end
        if (cyc1 === 1'b1 || cyc2 === 1'b1) begin
            checks++;
            if (!bus_allowed || cyc1 !== 1'b1 || cyc2 !== 1'b1 ||
                !txn_ok(we1, adr1, dat1, e1) || !txn_ok(we2, adr2, dat2, e2)) begin
                errors++;
                $display("FAIL bus_txn[%0d]: got we/adr/dat %b/%0d/%h and %b/%0d/%h, required %h and %h (allowed=%0b)",
                         idx, we1, adr1, dat1, we2, adr2, dat2, e1, e2, bus_allowed);
            end
        end
        if (cyc1 === 1'b1) begin
            ack = (scnt == 1) && (idx != no_ack_step);
            scnt++;
        end else begin
            ack = 1'b0;
            scnt = 0;
        end
        hs_prev = ack && cyc1;
        if (hs_prev && we1 && n_log < 16) begin
            log_adr1[n_log] = adr1;
            log_dat1[n_log] = dat1;
            log_dat2[n_log] = dat2;
            n_log++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Raise start so it is sampled at the next edge (edge 0); optionally keep it high.
    task automatic run_start(input bit hold);
        idx = 0;
        hs_prev = 0;
        n_log = 0;
        bus_allowed = 1;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
    endtask

    // Returns the edge number (counted from edge 0) at which done_o or err_o is first seen.
    task automatic wait_end(output int k);
        k = -1;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (done1 === 1'b1 || err1 === 1'b1) begin
                k = i;
                break;
            end
        end
        if (k < 0) begin
            errors++;
            $display("FAIL wait_end: no done/err within 80 cycles, required completion");
        end
    endtask

    initial begin
        int k;
        repeat (3) tick();
        chk("reset_busy", busy1, 0);
        chk("reset_done", done1, 0);
        chk("reset_err", err1, 0);
        chk("reset_cyc", cyc1, 0);
        chk("reset_outs", {adr1, dat1, we1, sel1}, 0);
        rst = 1'b0;
        tick();

        // Normal run: six writes, done at edge 18.
        run_start(0);
        chk("busy_after_start", busy1, 1);
        wait_end(k);
        chk("done_edge", k, N_STEPS * 3);
        chk("done1", done1, 1);
        chk("done2", done2, 1);
        chk("busy_at_done", busy1, 0);
        chk("err_at_done", err1, 0);
        chk("n_writes", n_log, 6);
        chk("w0", {log_adr1[0], log_dat1[0]}, {3'd3, 8'h83});
        chk("w1", {log_adr1[1], log_dat1[1]}, {3'd0, 8'h1B});
        chk("w2", {log_adr1[2], log_dat1[2]}, {3'd1, 8'h00});
        chk("w3", {log_adr1[3], log_dat1[3]}, {3'd3, 8'h03});
        chk("w4", {log_adr1[4], log_dat1[4]}, {3'd2, 8'hC7});
        chk("w5", {log_adr1[5], log_dat1[5]}, {3'd1, 8'h01});
        chk("div2_dll", log_dat2[1], 8'h45);
        chk("div2_dlm", log_dat2[2], 8'h01);
        repeat (3) tick();
        chk("done_sticky", done1, 1);

        // Timeout on step 2: strobes start after edge 6, 16 cycles, error at edge 22.
        no_ack_step = 2;
        run_start(0);
        chk("done_cleared", done1, 0);
        wait_end(k);
        chk("timeout_edge", k, 22);
        chk("timeout_err", err1, 1);
        chk("timeout_done", done1, 0);
        chk("timeout_cyc", cyc1, 0);
        chk("timeout_busy", busy1, 0);
        tick();
        chk("err_sticky", err1, 1);

        // Restart clears err and begins again from step 0.
        no_ack_step = 99;
        run_start(0);
        chk("restart_err_clr", err1, 0);
        chk("restart_step0", {adr1, dat1}, {3'd3, 8'h83});
        wait_end(k);
        chk("restart_done_edge", k, N_STEPS * 3);

        // start held high: no restart while busy, immediate restart after DONE.
        run_start(1);
        wait_end(k);
        chk("held_done_edge", k, N_STEPS * 3);
        tick();
        chk("held_restart_done", done1, 0);
        chk("held_restart_busy", busy1, 1);
        chk("held_restart_cyc", cyc1, 1);
        start = 1'b0;
        wait_end(k);
        chk("held_second_done", done1, 1);

        // Reset during first strobe cycle of step 3 (after edge 9).
        run_start(0);
        repeat (9) tick();
        chk("pre_reset_adr", {cyc1, adr1, dat1}, {1'b1, 3'd3, 8'h03});
        rst = 1'b1;
        tick();
        bus_allowed = 0;
        chk("rst_cyc", cyc1, 0);
        chk("rst_busy", busy1, 0);
        rst = 1'b0;
        repeat (10) tick();
        chk("rst_idle", {busy1, done1, err1, cyc1}, 0);

`ifdef PERIPHERAL_MSI_INIT_VERIFY_EN
        rd_data = 8'h07;
        run_start(0);
        wait_end(k);
        chk("verify_bad_edge", k, 20);
        chk("verify_bad_err", err1, 1);
        chk("verify_bad_done", done1, 0);
        rd_data = 8'h03;
        run_start(0);
        wait_end(k);
        chk("verify_ok_edge", k, 21);
        chk("verify_ok_done", done1, 1);
        chk("verify_ok_err", err1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
